// File: rtl/yj_rr_req_arbiter.sv
// Round-robin arbiter with optional request synchroniser,
// bounded grant hold and lockout of requesters that time out.
module yj_rr_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int SYNC_EN = 1,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            gnt_valid,
    output logic [IDW-1:0]  gnt_id,
    output logic            tmo_pulse,
    output logic [NREQ-1:0] lock_mask
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state;
    logic [NREQ-1:0] req_s;
    logic [NREQ-1:0] elig;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  sel_idx;
    logic [TMO_W-1:0] cnt;
    logic            hold;
    logic            tmo_hit;

    generate
        if (SYNC_EN != 0) begin : g_sync
            logic [NREQ-1:0] s1;
            logic [NREQ-1:0] s2;
            always_ff @(posedge CLK or negedge RSTn) begin
                if (!RSTn) begin
                    s1 <= '0;
                    s2 <= '0;
                end else begin
                    s1 <= req;
                    s2 <= s1;
                end
            end
            assign req_s = s2;
        end else begin : g_nosync
            assign req_s = req;
        end
    endgenerate

    assign elig = req_s & ~lock_mask;

    // Pick the eligible requester closest to ptr going upward with wrap.
    always_comb begin
        int best;
        int d;
        best    = NREQ;
        d       = 0;
        sel_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (k >= int'(ptr)) d = k - int'(ptr);
            else                d = k + NREQ - int'(ptr);
            if (elig[k] && d < best) begin
                best    = d;
                sel_idx = IDW'(k);
            end
        end
    end

    // gnt is one-hot in GRANT, so this is req_s of the current owner.
    assign hold    = |(req_s & gnt);
    assign tmo_hit = (state == GRANT) && hold &&
                     (cnt == TMO_W'(TMO_MAX - 1));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            tmo_pulse <= 1'b0;
            lock_mask <= '0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            lock_mask <= (lock_mask & req_s) | (tmo_hit ? gnt : '0);
            tmo_pulse <= tmo_hit;
            unique case (state)
                IDLE: begin
                    if (|elig) begin
                        gnt       <= NREQ'(1) << sel_idx;
                        gnt_id    <= sel_idx;
                        gnt_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!hold || tmo_hit) begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        gnt_id    <= '0;
                        ptr       <= (gnt_id == IDW'(NREQ - 1)) ?
                                     '0 : gnt_id + IDW'(1);
                        state     <= GAP;
                    end else begin
                        cnt <= cnt + TMO_W'(1);
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot: assert property (
        @(posedge CLK) disable iff (!RSTn) $onehot0(gnt)
    );
`endif

endmodule

// File: tb/tb_yj_rr_req_arbiter.sv
// Bench for yj_rr_req_arbiter: directed scenarios plus random
// request traffic checked every cycle against a behavioural model.
module tb_yj_rr_req_arbiter;

    localparam int N   = 4;
    localparam int TMO = 10;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       tmo_pulse;
    logic [3:0] lock_mask;

    logic [2:0] req3;
    logic [2:0] gnt3;
    logic       gv3;
    logic [1:0] id3;
    logic       tp3;
    logic [2:0] lk3;

    int n_vec = 0;
    int n_bad = 0;

    yj_rr_req_arbiter #(
        .NREQ(4), .IDW(2), .SYNC_EN(1), .TMO_W(8), .TMO_MAX(TMO)
    ) u_dut (
        .CLK(CLK), .RSTn(RSTn), .req(req), .gnt(gnt),
        .gnt_valid(gnt_valid), .gnt_id(gnt_id),
        .tmo_pulse(tmo_pulse), .lock_mask(lock_mask)
    );

    yj_rr_req_arbiter #(
        .NREQ(3), .IDW(2), .SYNC_EN(0), .TMO_W(8), .TMO_MAX(TMO)
    ) u_dut3 (
        .CLK(CLK), .RSTn(RSTn), .req(req3), .gnt(gnt3),
        .gnt_valid(gv3), .gnt_id(id3),
        .tmo_pulse(tp3), .lock_mask(lk3)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: owner index, cycles held, next start point.
    int         m_owner;
    int         m_held;
    int         m_next;
    bit         m_gap;
    bit         m_tmo;
    bit         m_lock [N];
    logic [3:0] q [$];

    function automatic void model_reset();
        m_owner = -1;
        m_held  = 0;
        m_next  = 0;
        m_gap   = 0;
        m_tmo   = 0;
        for (int k = 0; k < N; k++) m_lock[k] = 0;
        q = '{4'b0000, 4'b0000};
    endfunction

    function automatic void model_step(logic [3:0] r);
        logic [3:0] rs;
        bit nl [N];
        bit to;
        to = 0;
        rs = q.pop_front();
        q.push_back(r);
        for (int k = 0; k < N; k++) nl[k] = m_lock[k] && rs[k];
        if (m_owner >= 0) begin
            if (!rs[m_owner]) begin
                m_next  = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1;
            end else if (m_held == TMO) begin
                to          = 1;
                nl[m_owner] = 1;
                m_next      = (m_owner + 1) % N;
                m_owner     = -1;
                m_gap       = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_next + i) % N;
                if (m_owner < 0 && rs[k] && !m_lock[k]) begin
                    m_owner = k;
                    m_held  = 1;
                end
            end
        end
        for (int k = 0; k < N; k++) m_lock[k] = nl[k];
        m_tmo = to;
    endfunction

    function automatic logic [11:0] exp_vec();
        logic [3:0] g;
        logic [1:0] id;
        logic [3:0] lk;
        g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        for (int k = 0; k < N; k++) lk[k] = m_lock[k];
        return {g, (m_owner >= 0), id, m_tmo, lk};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {gnt, gnt_valid, gnt_id, tmo_pulse, lock_mask};
    endfunction

    task automatic tick();
        logic [3:0] r;
        r = req;
        @(posedge CLK);
        model_step(r);
        #1;
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        req  = 4'b0000;
        req3 = 3'b000;
        @(negedge CLK);
        model_reset();
        RSTn = 1'b1;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        req  = 4'b1111;
        req3 = 3'b111;
        repeat (2) @(negedge CLK);
        n_vec++;
        if ({dut_vec(), gnt3, gv3, id3, tp3, lk3} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h/%h want 0",
                     dut_vec(), {gnt3, gv3, id3, tp3, lk3});
        end
        model_reset();
        req3 = 3'b000;
        RSTn = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_vec edge %0d: got %h want %h",
                         i, dut_vec(), exp_vec());
            end
            n_vec++;
            if (i == 2 && gnt !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_latency_early: got %b want 0000", gnt);
            end else if (i == 3 && {gnt, gnt_id} !== {4'b0001, 2'd0}) begin
                n_bad++;
                $display("FAIL reset_latency: got %b/%0d want 0001/0",
                         gnt, gnt_id);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        int got [$];
        int up_at [N];
        int gstart, prev_owner, len, nfall;
        bit pv;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < N; k++) up_at[k] = -1;
        gstart = -100; prev_owner = -1; len = 0; nfall = 0; pv = 0;
        for (int cyc = 0; cyc < 150 && got.size() < 5; cyc++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rr_vec cyc %0d: got %h want %h",
                         cyc, dut_vec(), exp_vec());
            end
            if (gnt_valid && !pv) got.push_back(int'(gnt_id));
            if (gnt_valid) len++;
            if (pv && !gnt_valid) begin
                n_vec++;
                if (len != 5) begin
                    n_bad++;
                    $display("FAIL rr_len grant %0d: got %0d want 5",
                             nfall, len);
                end
                len = 0;
                nfall++;
            end
            pv = gnt_valid;
            if (m_owner >= 0 && m_owner != prev_owner) gstart = cyc;
            if (m_owner >= 0 && cyc == gstart + 2) begin
                req[m_owner]  = 1'b0;
                up_at[m_owner] = cyc + 2;
            end
            for (int k = 0; k < N; k++)
                if (up_at[k] == cyc) req[k] = 1'b1;
            prev_owner = m_owner;
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (i >= got.size()) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got none want %0d",
                         i, exp_ord[i]);
            end else if (got[i] != exp_ord[i]) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got %0d want %0d",
                         i, got[i], exp_ord[i]);
            end
        end
    endtask

    task automatic test_wrap_skip();
        int got [$];
        bit pv;
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) req = 4'b0000;
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL wrap_vec: got %h want %h",
                         dut_vec(), exp_vec());
            end
        end
        req = 4'b0101;
        pv  = 0;
        for (int i = 0; i < 30 && got.size() < 2; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL wrap_vec2: got %h want %h",
                         dut_vec(), exp_vec());
            end
            if (gnt_valid && !pv) got.push_back(int'(gnt_id));
            pv = gnt_valid;
            if (m_owner == 0) req[0] = 1'b0;
        end
        n_vec++;
        if (got.size() < 2 || got[0] != 0 || got[1] != 2) begin
            n_bad++;
            $display("FAIL wrap_order: got %p want '{0, 2}", got);
        end
    endtask

    task automatic test_nreq3();
        do_reset();
        req3 = 3'b010;
        tick();
        n_vec++;
        if ({gnt3, id3} !== {3'b010, 2'd1}) begin
            n_bad++;
            $display("FAIL n3_first: got %b/%0d want 010/1", gnt3, id3);
        end
        req3 = 3'b000;
        tick();
        n_vec++;
        if (gnt3 !== 3'b000) begin
            n_bad++;
            $display("FAIL n3_release: got %b want 000", gnt3);
        end
        req3 = 3'b011;
        tick();
        tick();
        n_vec++;
        if ({gnt3, id3, gv3} !== {3'b001, 2'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL n3_wrap: got %b/%0d want 001/0", gnt3, id3);
        end
        req3 = 3'b000;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) req3 = 3'b100;
            tick();
            n_vec++;
            if (id3 > 2'd2 || lk3 !== 3'b000) begin
                n_bad++;
                $display("FAIL n3_range: got id %0d lock %b want <3/000",
                         id3, lk3);
            end
        end
    endtask

    task automatic test_timeout();
        int len;
        bit pv, seen;
        do_reset();
        req = 4'b0010;
        len = 0; pv = 0; seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL tmo_vec: got %h want %h",
                         dut_vec(), exp_vec());
            end
            if (gnt[1]) len++;
            if (pv && !gnt[1]) begin
                seen = 1;
                n_vec++;
                if ({tmo_pulse, lock_mask} !== {1'b1, 4'b0010}) begin
                    n_bad++;
                    $display("FAIL tmo_revoke: got %b/%b want 1/0010",
                             tmo_pulse, lock_mask);
                end
                break;
            end
            pv = gnt[1];
        end
        n_vec++;
        if (!seen || len != TMO) begin
            n_bad++;
            $display("FAIL tmo_len: got %0d want %0d", len, TMO);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if (gnt_valid || dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL tmo_locked: got %h want %h",
                         dut_vec(), exp_vec());
            end
        end
        req = 4'b0000;
        repeat (3) tick();
        n_vec++;
        if (lock_mask !== 4'b0000 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL tmo_unlock: got %b want 0000", lock_mask);
        end
        req  = 4'b0010;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (gnt === 4'b0010) seen = 1;
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL tmo_regrant: got %b want 0010", gnt);
        end
    endtask

    task automatic test_drop_at_timeout();
        int len;
        bit seen;
        do_reset();
        req  = 4'b0100;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (gnt === 4'b0100) seen = 1;
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL drop_grant: got %b want 0100", gnt);
        end
        len = 1;
        repeat (7) begin
            tick();
            if (gnt[2]) len++;
        end
        req = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gnt[2]) len++;
            n_vec++;
            if (tmo_pulse || lock_mask !== 4'b0000 ||
                dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL drop_tmo: got %h want %h",
                         dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (len != TMO) begin
            n_bad++;
            $display("FAIL drop_len: got %0d want %0d", len, TMO);
        end
    endtask

    task automatic test_reset_mid_grant();
        bit seen;
        do_reset();
        req = 4'b0001;
        repeat (6) tick();
        req  = 4'b0100;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL mid_vec: got %h want %h",
                         dut_vec(), exp_vec());
            end
            if (gnt === 4'b0100) seen = 1;
        end
        tick();
        #2;
        RSTn = 1'b0;
        #1;
        n_vec++;
        if (!seen || {gnt, gnt_valid} !== 5'b0) begin
            n_bad++;
            $display("FAIL mid_async: got %b/%b want 0000/0 seen %0d",
                     gnt, gnt_valid, seen);
        end
        req = 4'b0011;
        @(negedge CLK);
        model_reset();
        RSTn = 1'b1;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (gnt_valid) seen = 1;
        end
        n_vec++;
        if (!seen || gnt_id !== 2'd0 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL mid_restart: got %h want %h",
                     dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0)
                req[$urandom_range(0, 3)] ^= 1'b1;
            tick();
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rand_vec cyc %0d: got %h want %h",
                         i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        RSTn = 1'b0;
        req  = 4'b0000;
        req3 = 3'b000;
        model_reset();
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_nreq3();
        test_timeout();
        test_drop_at_timeout();
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
